// File: rtl/p02_factory_pattern_checker_if.sv
// Pin bundle between the pattern checker and whatever drives its tile pins.
interface p02_factory_pattern_checker_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/p02_factory_pattern_checker.sv
// Receive-side checker for the factory incrementing test pattern: locks onto an
// 8-bit +1 (mod 256) stream on uio_in, counts good/bad steps, reports status on uo_out.
module p02_factory_pattern_checker #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_LIMIT  = 8,
  parameter int unsigned PASS_COUNT = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  p02_factory_pattern_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_FAIL    = 2'd3
  } state_t;

  localparam logic [4:0]  LOCK_TGT = 5'(LOCK_COUNT);
  localparam logic [8:0]  ERR_TGT  = 9'(ERR_LIMIT);
  localparam logic [16:0] PASS_TGT = 17'(PASS_COUNT);

  logic        rst_i;
  state_t      state_q;
  logic        en_q;
  logic [7:0]  smp_q;
  logic [7:0]  lst_q;
  logic [1:0]  fill_q;
  logic [3:0]  lock_run_q;
  logic [7:0]  err_cnt_q;
  logic [15:0] good_cnt_q;
  logic        any_err_q;

  logic        en;
  logic [1:0]  view;
  logic        hit;
  logic        miss;
  logic [4:0]  lock_next;
  logic [8:0]  err_next;
  logic        locked;
  logic        fail;
  logic        pass;
  logic [7:0]  uo_view;
  logic        unused_pins;

  assign en   = bus.ui_in[0];
  assign view = bus.ui_in[2:1];
  assign unused_pins = &{1'b0, bus.ena, bus.ui_in[7:3]};

  assign hit  = (fill_q == 2'd2) && (smp_q == lst_q + 8'd1);
  assign miss = (fill_q == 2'd2) && !hit;

  assign lock_next = {1'b0, lock_run_q} + 5'd1;
  assign err_next  = {1'b0, err_cnt_q} + 9'd1;

  assign locked = (state_q == ST_TRACK);
  assign fail   = (state_q == ST_FAIL);
  assign pass   = locked && ({1'b0, good_cnt_q} >= PASS_TGT) && (err_cnt_q == '0);

  // Internal reset: asserts with rst_n, releases on the first clk edge after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_i <= 1'b1;
    else        rst_i <= 1'b0;
  end

  // Sampling pipeline, lock/track state machine and step counters.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      smp_q      <= '0;
      lst_q      <= '0;
      fill_q     <= '0;
      lock_run_q <= '0;
      err_cnt_q  <= '0;
      good_cnt_q <= '0;
      any_err_q  <= 1'b0;
    end else begin
      en_q <= en;
      if (en) begin
        smp_q <= bus.uio_in;
        lst_q <= smp_q;
      end
      if (en && !en_q) begin
        // Enable rise restarts acquisition; a coincident hit is deliberately dropped.
        fill_q     <= '0;
        lock_run_q <= '0;
        err_cnt_q  <= '0;
        good_cnt_q <= '0;
        any_err_q  <= 1'b0;
        state_q    <= ST_ACQUIRE;
      end else if (!en) begin
        fill_q  <= '0;
        state_q <= ST_IDLE;
      end else begin
        if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
        case (state_q)
          ST_ACQUIRE: begin
            if (hit) begin
              if (lock_next == LOCK_TGT) begin
                lock_run_q <= '0;
                state_q    <= ST_TRACK;
              end else begin
                lock_run_q <= lock_next[3:0];
              end
            end else if (miss) begin
              lock_run_q <= '0;
            end
          end
          ST_TRACK: begin
            if (hit) begin
              if (good_cnt_q != '1) good_cnt_q <= good_cnt_q + 16'd1;
            end else if (miss) begin
              if (err_cnt_q != '1) err_cnt_q <= err_next[7:0];
              any_err_q <= 1'b1;
              if (err_next >= ERR_TGT) state_q <= ST_FAIL;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Status / counter view multiplexer.
  always_comb begin
    uo_view = '0;
    case (view)
      2'd0:    uo_view = {2'b00, state_q, any_err_q, pass, fail, locked};
      2'd1:    uo_view = err_cnt_q;
      2'd2:    uo_view = good_cnt_q[7:0];
      default: uo_view = good_cnt_q[15:8];
    endcase
  end

  assign bus.uo_out  = uo_view;
  assign bus.uio_out = '0;
  assign bus.uio_oe  = '0;

endmodule

// File: tb/tb_p02_factory_pattern_checker.sv
// Randomised + directed bench for the factory pattern checker, checked against a
// step-level behavioural model of the lock/track/fail rules.
module tb_p02_factory_pattern_checker;

  localparam int LOCK_COUNT = 4;
  localparam int ERR_LIMIT  = 8;
  localparam int PASS_COUNT = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  p02_factory_pattern_checker_if bus();

  p02_factory_pattern_checker #(
    .LOCK_COUNT(LOCK_COUNT),
    .ERR_LIMIT (ERR_LIMIT),
    .PASS_COUNT(PASS_COUNT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: mode uses the documented status encoding (0 idle, 1 acquire, 2 track, 3 fail).
  int m_mode, m_run, m_err, m_good, m_seen;
  bit m_any, m_prev_en, m_rst;
  int hist[$];

  function automatic void model_clear();
    m_mode = 0; m_run = 0; m_err = 0; m_good = 0; m_seen = 0;
    m_any = 0; m_prev_en = 0;
    hist.delete();
  endfunction

  function automatic void model_edge(bit en, logic [7:0] d);
    bit ok;
    if (m_rst) begin
      if (rst_n) m_rst = 0;
      model_clear();
      return;
    end
    if (en && !m_prev_en) begin
      m_run = 0; m_err = 0; m_good = 0; m_any = 0; m_mode = 1;
      hist.delete();
      hist.push_back(int'(d));
      m_seen = 1;
    end else if (!en) begin
      m_mode = 0;
      m_seen = 0;
    end else begin
      if (m_seen >= 3) begin
        ok = ((hist[hist.size()-2] + 1) % 256) == hist[hist.size()-1];
        if (m_mode == 1) begin
          if (ok) begin
            m_run++;
            if (m_run == LOCK_COUNT) begin m_mode = 2; m_run = 0; end
          end else m_run = 0;
        end else if (m_mode == 2) begin
          if (ok) m_good = (m_good < 65535) ? m_good + 1 : 65535;
          else begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
            m_any = 1;
            if (m_err >= ERR_LIMIT) m_mode = 3;
          end
        end
      end
      hist.push_back(int'(d));
      if (hist.size() > 2) void'(hist.pop_front());
      m_seen++;
    end
    m_prev_en = en;
  endfunction

  function automatic logic [7:0] m_view(int v);
    int r;
    bit locked, pass;
    locked = (m_mode == 2);
    pass   = locked && (m_good >= PASS_COUNT) && (m_err == 0);
    case (v)
      0: r = (m_mode << 4) | (int'(m_any) << 3) | (int'(pass) << 2) |
             (int'(m_mode == 3) << 1) | int'(locked);
      1: r = m_err;
      2: r = m_good % 256;
      default: r = m_good / 256;
    endcase
    return 8'(r);
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  // Checks every view plus the constant pins against the model (takes 4 time units).
  task automatic compare_all();
    for (int v = 0; v < 4; v++) begin
      bus.ui_in[2:1] = 2'(v);
      #1;
      chk($sformatf("view%0d", v), bus.uo_out, m_view(v));
    end
    chk("uio_out", bus.uio_out, 8'h00);
    chk("uio_oe",  bus.uio_oe,  8'h00);
  endtask

  // Literal check of one view (takes 1 time unit).
  task automatic pin(input int v, input logic [7:0] exp, input string name);
    bus.ui_in[2:1] = 2'(v);
    #1;
    chk(name, bus.uo_out, exp);
  endtask

  task automatic step(input bit en, input logic [7:0] d);
    bus.ui_in[0] = en;
    bus.uio_in   = d;
    @(posedge clk);
    model_edge(en, d);
    #1;
    compare_all();
  endtask

  task automatic run_from(input logic [7:0] start, input int n, output logic [7:0] next);
    logic [7:0] d;
    d = start;
    for (int i = 0; i < n; i++) begin
      step(1'b1, d);
      d = d + 8'd1;
    end
    next = d;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    bit en_r;
    int off_left;

    bus.ena    = 1'b1;
    bus.ui_in  = '0;
    bus.uio_in = '0;
    rst_n      = 1'b0;
    m_rst      = 1;
    model_clear();

    // T1: reset state in every view
    compare_all();
    @(negedge clk);
    pin(0, 8'h00, "rst_view00");
    pin(1, 8'h00, "rst_view01");
    pin(2, 8'h00, "rst_view10");
    pin(3, 8'h00, "rst_view11");
    rst_n = 1'b1;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);

    // T2: lock onto 0x10.. within LOCK_COUNT+3 edges
    run_from(8'h10, 7, d);
    pin(0, 8'h21, "lock_view00");
    run_from(d, 3, d);
    pin(2, 8'h03, "lock_good3");

    // T3: wrap through FF->00 without errors
    step(1'b0, 8'h00);
    run_from(8'hF0, 7, d);
    run_from(d, 15, d);
    pin(1, 8'h00, "wrap_err");
    pin(2, 8'h0F, "wrap_good");

    // T4: single glitch value costs two errors, tracking continues
    while (d != 8'h21) begin
      step(1'b1, d);
      d = d + 8'd1;
    end
    step(1'b1, 8'h55);
    run_from(8'h22, 6, d);
    pin(1, 8'h02, "glitch_err");
    pin(0, 8'h29, "glitch_view00");

    // T5: stuck input drives FAIL, sticky until en re-rises
    step(1'b0, 8'h00);
    run_from(8'h30, 7, d);
    for (int i = 0; i < 10; i++) step(1'b1, 8'h42);
    pin(0, 8'h3A, "fail_view00");
    pin(1, 8'h08, "fail_err");
    run_from(8'h43, 5, d);
    pin(1, 8'h08, "fail_frozen_err");
    pin(0, 8'h3A, "fail_sticky");
    step(1'b0, d);
    step(1'b1, d);
    pin(1, 8'h00, "rerise_err");
    pin(0, 8'h10, "rerise_view00");

    // T6: long clean run asserts pass; reset mid-stream clears at once
    step(1'b0, 8'h00);
    run_from(8'h00, 7 + 300, d);
    pin(0, 8'h25, "pass_view00");
    pin(3, 8'h01, "pass_view11");
    rst_n = 1'b0;
    m_rst = 1;
    model_clear();
    pin(0, 8'h00, "midrst_view00");
    pin(1, 8'h00, "midrst_view01");
    pin(2, 8'h00, "midrst_view10");
    pin(3, 8'h00, "midrst_view11");
    step(1'b1, d);
    step(1'b1, d + 8'd1);
    rst_n = 1'b1;
    run_from(8'h80, 12, d);

    // Random phase: mostly clean stream with glitches, stuck runs, enable drops and resets
    en_r = 1'b1;
    off_left = 0;
    for (int i = 0; i < 2000; i++) begin
      if (off_left > 0) begin
        off_left--;
        en_r = (off_left == 0);
      end else if ($urandom_range(63) == 0) begin
        off_left = int'($urandom_range(3, 1));
        en_r = 1'b0;
      end
      case ($urandom_range(99))
        0, 1, 2:  d = 8'($urandom);
        3, 4:     d = d;
        default:  d = d + 8'd1;
      endcase
      if ($urandom_range(199) == 0) begin
        for (int k = 0; k < 12; k++) step(en_r, d);
      end
      if ($urandom_range(499) == 0) begin
        rst_n = 1'b0;
        m_rst = 1;
        model_clear();
        step(en_r, d);
        rst_n = 1'b1;
      end
      step(en_r, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
